// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - processor/memory handshake bundle for cache_controller
//
// Purpose: groups the scalar processor-side request/stall signals and the
// memory-side burst control signals. The bidirectional data buses stay as
// plain inout ports on the controller.
//
// Signals:
//   addr_up   [31:0]  processor byte address
//   read_up           processor read request
//   write_up          processor write request
//   stall_up          controller: request cannot complete this cycle
//   addr_mem  [31:0]  controller: memory word byte address
//   read_mem          controller: refill burst request
//   write_mem         controller: write-back burst request
//   ready_mem         memory idle / ready to transfer
//
// Modports:
//   master  processor + memory environment
//   slave   the cache controller
`timescale 1ns/1ps
interface cache_controller_if;
  logic [31:0] addr_up;
  logic        read_up;
  logic        write_up;
  logic        stall_up;
  logic [31:0] addr_mem;
  logic        read_mem;
  logic        write_mem;
  logic        ready_mem;

  modport master (
    output addr_up, read_up, write_up, ready_mem,
    input  stall_up, addr_mem, read_mem, write_mem
  );

  modport slave (
    input  addr_up, read_up, write_up, ready_mem,
    output stall_up, addr_mem, read_mem, write_mem
  );
endinterface

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back write-allocate data cache controller
//
// Purpose: serves processor read/write hits in one cycle; on a miss stalls the
// processor, writes back a dirty victim line as a WORDS-beat burst, then
// refills the line as a WORDS-beat burst and lets the held request re-hit.
//
// Ports:
//   clk       rising-edge clock shared with the processor
//   reset     synchronous, active-high
//   bus       cache_controller_if.slave (addr_up, read_up, write_up, stall_up,
//             addr_mem, read_mem, write_mem, ready_mem)
//   data_up   inout, driven by the controller only in the READ cycle
//   data_mem  inout, driven by the controller only while write_mem=1
`timescale 1ns/1ps
module cache_controller #(
  parameter int LINES = 64,
  parameter int WORDS = 4
) (
  input  logic               clk,
  input  logic               reset,
  cache_controller_if.slave  bus,
  inout  wire  [31:0]        data_up,
  inout  wire  [31:0]        data_mem
);

  localparam int IW = $clog2(LINES);
  localparam int OW = $clog2(WORDS);
  localparam int TW = 32 - IW - OW - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_WRITEBACK,
    S_REFILL_WAIT,
    S_REFILL
  } state_t;

  state_t state_q, state_d;

  logic [31:0]    mem_q [LINES*WORDS];
  logic [TW-1:0]  tag_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  logic [OW-1:0]  cnt_q, cnt_d;
  // first_q marks the entry cycle of a burst state, where ready_mem is stale
  logic           first_q, first_d;
  // xfer_q: write-back has seen ready_mem and is moving words
  logic           xfer_q, xfer_d;
  logic [31:0]    req_addr_q;

  logic           up_oe, mem_oe;
  logic           wr_word, fill_word, fill_done, wb_done;

  // Live decode of the incoming request (used only in IDLE)
  logic [IW-1:0]  in_idx;
  logic [TW-1:0]  in_tag;
  logic           hit;

  // Decode of the latched request (used in every other state)
  logic [IW-1:0]  r_idx;
  logic [OW-1:0]  r_off;
  logic [TW-1:0]  r_tag;

  assign in_idx = bus.addr_up[IW+OW+1:OW+2];
  assign in_tag = bus.addr_up[31:IW+OW+2];
  assign hit    = valid_q[in_idx] && (tag_q[in_idx] == in_tag);

  assign r_idx  = req_addr_q[IW+OW+1:OW+2];
  assign r_off  = req_addr_q[OW+1:2];
  assign r_tag  = req_addr_q[31:IW+OW+2];

  assign data_up  = up_oe  ? mem_q[{r_idx, r_off}] : {32{1'bz}};
  assign data_mem = mem_oe ? mem_q[{r_idx, cnt_q}] : {32{1'bz}};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    first_d       = 1'b0;
    xfer_d        = xfer_q;
    bus.stall_up  = 1'b0;
    bus.read_mem  = 1'b0;
    bus.write_mem = 1'b0;
    bus.addr_mem  = 32'd0;
    up_oe         = 1'b0;
    mem_oe        = 1'b0;
    wr_word       = 1'b0;
    fill_word     = 1'b0;
    fill_done     = 1'b0;
    wb_done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.write_up || bus.read_up) begin
          if (hit) begin
            state_d = bus.write_up ? S_WRITE : S_READ;
          end else begin
            bus.stall_up = 1'b1;
            first_d      = 1'b1;
            cnt_d        = '0;
            xfer_d       = 1'b0;
            state_d      = dirty_q[in_idx] ? S_WRITEBACK : S_REFILL_WAIT;
          end
        end
      end

      S_READ: begin
        up_oe   = 1'b1;
        state_d = S_IDLE;
      end

      S_WRITE: begin
        wr_word = 1'b1;
        state_d = S_IDLE;
      end

      S_WRITEBACK: begin
        bus.stall_up  = 1'b1;
        bus.write_mem = 1'b1;
        mem_oe        = 1'b1;
        bus.addr_mem  = {tag_q[r_idx], r_idx, cnt_q, 2'b00};
        if (xfer_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == OW'(WORDS - 1)) begin
            wb_done = 1'b1;
            xfer_d  = 1'b0;
            cnt_d   = '0;
            first_d = 1'b1;
            state_d = S_REFILL_WAIT;
          end
        end else if (!first_q && bus.ready_mem) begin
          xfer_d = 1'b1;
          cnt_d  = '0;
        end
      end

      S_REFILL_WAIT: begin
        bus.stall_up = 1'b1;
        bus.read_mem = 1'b1;
        bus.addr_mem = {req_addr_q[31:OW+2], {(OW+2){1'b0}}};
        if (!first_q && bus.ready_mem) begin
          cnt_d   = '0;
          state_d = S_REFILL;
        end
      end

      S_REFILL: begin
        bus.stall_up = 1'b1;
        bus.read_mem = 1'b1;
        bus.addr_mem = {req_addr_q[31:OW+2], cnt_q, 2'b00};
        fill_word    = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == OW'(WORDS - 1)) begin
          fill_done = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      xfer_q     <= 1'b0;
      req_addr_q <= 32'd0;
      valid_q    <= '1;
      dirty_q    <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      for (int i = 0; i < LINES * WORDS; i++) mem_q[i] <= 32'd3;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      xfer_q  <= xfer_d;
      // Latch the request on leaving IDLE so later states never depend on
      // the processor keeping addr_up steady past its own stall window.
      if (state_q == S_IDLE) req_addr_q <= bus.addr_up;
      if (wr_word) begin
        mem_q[{r_idx, r_off}] <= data_up;
        dirty_q[r_idx]        <= 1'b1;
      end
      if (fill_word) mem_q[{r_idx, cnt_q}] <= data_mem;
      if (wb_done) dirty_q[r_idx] <= 1'b0;
      if (fill_done) begin
        tag_q[r_idx]   <= r_tag;
        valid_q[r_idx] <= 1'b1;
        dirty_q[r_idx] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - scoreboard testbench for cache_controller
`timescale 1ns/1ps
module tb_cache_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_controller_if bus();
  wire  [31:0] data_up;
  wire  [31:0] data_mem;
  logic        up_drv  = 1'b0;
  logic [31:0] up_val  = 32'd0;
  logic        mem_drv = 1'b0;
  logic [31:0] mem_val = 32'd0;

  assign data_up  = up_drv  ? up_val  : {32{1'bz}};
  assign data_mem = mem_drv ? mem_val : {32{1'bz}};

  cache_controller #(.LINES(64), .WORDS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .data_up  (data_up),
    .data_mem (data_mem)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_rd [$];
  logic [63:0] exp_wb [$];
  logic [31:0] rf_addr [$];
  logic [31:0] rf_data [$];
  int          mem_delay    = 2;
  logic        overlap_seen = 1'b0;
  int          mm_state     = 0;
  int          mm_k         = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  task automatic fail_empty(input string nm, input logic [31:0] act);
    total_cnt++;
    $display("FAIL %s: actual %h required no transfer (nothing expected)", nm, act);
  endtask

  // Read-data monitor: a cycle with read_up && !stall_up in IDLE is followed
  // by the READ cycle in which data_up carries the word.
  initial begin : rd_mon
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (pend && !reset) begin
        if (exp_rd.size() == 0) fail_empty("read_data", data_up);
        else check("read_data", data_up, exp_rd.pop_front());
      end
      pend = bus.read_up && !bus.write_up && !bus.stall_up && !reset;
    end
  end

  // Memory model and burst monitor
  initial begin : mem_model
    int   dly;
    logic wr;
    logic [63:0] e;
    dly = 0;
    wr  = 1'b0;
    bus.ready_mem = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.read_mem && bus.write_mem) overlap_seen = 1'b1;
      if (reset) begin
        mm_state = 0;
        bus.ready_mem = 1'b1;
        mem_drv = 1'b0;
      end else begin
        case (mm_state)
          0: begin
            mem_drv = 1'b0;
            if (bus.read_mem || bus.write_mem) begin
              wr = bus.write_mem;
              bus.ready_mem = 1'b0;
              dly = mem_delay;
              mm_state = 1;
            end
          end
          1: begin
            if (dly == 0) begin
              bus.ready_mem = 1'b1;
              mm_k = 0;
              mm_state = 2;
            end else begin
              dly--;
            end
          end
          default: begin
            if (wr) begin
              if (exp_wb.size() == 0) fail_empty("wb_addr", bus.addr_mem);
              else begin
                e = exp_wb.pop_front();
                check("wb_addr", bus.addr_mem, e[63:32]);
                check("wb_data", data_mem, e[31:0]);
              end
            end else begin
              if (rf_addr.size() == 0) fail_empty("rf_addr", bus.addr_mem);
              else check("rf_addr", bus.addr_mem, rf_addr.pop_front());
              mem_val = (rf_data.size() != 0) ? rf_data.pop_front() : 32'hDEADBEEF;
              mem_drv = 1'b1;
            end
            mm_k++;
            if (mm_k == 4) mm_state = 0;
          end
        endcase
      end
    end
  end

  // Tasks start 1ns after a rising edge with the controller in IDLE.
  task automatic wait_unstall(input logic exp_hit, input string nm);
    int stalls;
    stalls = 0;
    @(negedge clk);
    while (bus.stall_up && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    if (bus.stall_up) begin
      total_cnt++;
      $display("FAIL %s_timeout: actual stall_up=1 after %0d cycles required 0", nm, stalls);
    end
    check({nm, "_hit"}, 32'(stalls == 0), 32'(exp_hit));
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input logic exp_hit,
                         input string nm);
    exp_rd.push_back(exp);
    bus.addr_up = a;
    bus.read_up = 1'b1;
    wait_unstall(exp_hit, nm);
    @(posedge clk); #1;
    bus.read_up = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic exp_hit,
                          input string nm);
    bus.addr_up  = a;
    bus.write_up = 1'b1;
    up_val = d;
    up_drv = 1'b1;
    wait_unstall(exp_hit, nm);
    @(posedge clk); #1;
    bus.write_up = 1'b0;
    @(posedge clk); #1;
    up_drv = 1'b0;
  endtask

  task automatic push_refill(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
    for (int i = 0; i < 4; i++) rf_addr.push_back(base + 32'(4 * i));
    rf_data.push_back(d0);
    rf_data.push_back(d1);
    rf_data.push_back(d2);
    rf_data.push_back(d3);
  endtask

  task automatic push_wb(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
    exp_wb.push_back({base,          d0});
    exp_wb.push_back({base + 32'd4,  d1});
    exp_wb.push_back({base + 32'd8,  d2});
    exp_wb.push_back({base + 32'd12, d3});
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t;
    reset = 1'b1;
    bus.addr_up  = 32'd0;
    bus.read_up  = 1'b0;
    bus.write_up = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall_up",  32'(bus.stall_up),  32'd0);
    check("rst_read_mem",  32'(bus.read_mem),  32'd0);
    check("rst_write_mem", 32'(bus.write_mem), 32'd0);
    check("rst_addr_mem",  bus.addr_mem,       32'd0);
    @(posedge clk); #1;

    // Hits on reset-initialised contents
    do_read(32'h0000_0000, 32'd3, 1'b1, "rd0_init");
    do_write(32'h0000_0000, 32'd100, 1'b1, "wr0");
    do_read(32'h0000_0000, 32'd100, 1'b1, "rd0_after_wr");

    // Clean read miss, index 9, memory holds ready low for a while
    mem_delay = 4;
    push_refill(32'hC000_0090, 32'h0000, 32'h1111, 32'h2222, 32'h3333);
    do_read(32'hC000_0091, 32'h0000, 1'b0, "rd_miss_c0");
    do_read(32'hC000_0094, 32'h1111, 1'b1, "rd_hit_c4");
    mem_delay = 2;

    // Dirty eviction of index 1
    do_write(32'h0000_0010, 32'h55, 1'b1, "wr10");
    push_wb(32'h0000_0010, 32'h55, 32'd3, 32'd3, 32'd3);
    push_refill(32'h8000_8010, 32'hAAAA, 32'hBBBB, 32'hCCCC, 32'hDDDD);
    do_read(32'h8000_8010, 32'hAAAA, 1'b0, "rd_evict1");
    push_refill(32'h0000_0010, 32'h10, 32'h11, 32'h12, 32'h13);
    do_read(32'h0000_0010, 32'h10, 1'b0, "rd10_remiss");

    // Line 0 is dirty from the earlier write
    push_wb(32'h0000_0000, 32'd100, 32'd3, 32'd3, 32'd3);
    push_refill(32'h8000_0000, 32'h50, 32'h51, 32'h52, 32'h53);
    do_read(32'h8000_0008, 32'h52, 1'b0, "rd_evict0");

    // Write miss (write-allocate) at index 2, offset 1
    mem_delay = 0;
    push_refill(32'h4000_0020, 32'h20, 32'h21, 32'h22, 32'h23);
    do_write(32'h4000_0024, 32'd7, 1'b0, "wr_miss");
    do_read(32'h4000_0024, 32'd7, 1'b1, "rd_wr_miss");
    push_wb(32'h4000_0020, 32'h20, 32'd7, 32'h22, 32'h23);
    push_refill(32'h0000_0020, 32'h30, 32'h31, 32'h32, 32'h33);
    do_read(32'h0000_002C, 32'h33, 1'b0, "rd_evict2");
    mem_delay = 1;

    // Reset in the middle of a refill burst
    push_refill(32'hC000_00A0, 32'h1, 32'h2, 32'h3, 32'h4);
    bus.addr_up = 32'hC000_00A0;
    bus.read_up = 1'b1;
    t = 0;
    while (!(mm_state == 2 && mm_k == 2) && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (t >= 200) begin
      total_cnt++;
      $display("FAIL mid_refill_timeout: actual no refill beat required refill in progress");
    end
    #1;
    reset = 1'b1;
    bus.read_up = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_read_mem", 32'(bus.read_mem), 32'd0);
    check("mid_rst_stall_up", 32'(bus.stall_up), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rf_addr.delete();
    rf_data.delete();
    do_read(32'h0000_0000, 32'd3, 1'b1, "rd0_post_rst");
    do_read(32'h0000_0010, 32'd3, 1'b1, "rd10_post_rst");

    repeat (3) @(posedge clk);
    check("rd_queue_empty",   32'(exp_rd.size()),  32'd0);
    check("wb_queue_empty",   32'(exp_wb.size()),  32'd0);
    check("rf_queue_empty",   32'(rf_addr.size()), 32'd0);
    check("no_rd_wr_overlap", 32'(overlap_seen),   32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
